// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register with stall/redirect control, IF/ID
// pipeline register and saturating fetch/stall/flush performance counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    input  logic [31:0]      IM_Data,
    output logic [31:0]      IM_Addr,
    output logic [31:0]      PC,
    output logic [31:0]      IF_ID_Instr,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic [4:0]       IF_ID_Rs,
    output logic [4:0]       IF_ID_Rt,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] FetchCount,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_id_instr_q, if_id_instr_d;
    logic [31:0]      if_id_pcplus4_q, if_id_pcplus4_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:0]      pc_plus4;
    logic             redirect;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        // A stalled PC cannot accept a redirect; ID must re-present it later.
        redirect = PCWrite & (Jump | BranchTaken);

        pc_d            = pc_q;
        if_id_instr_d   = if_id_instr_q;
        if_id_pcplus4_d = if_id_pcplus4_q;
        if_id_valid_d   = if_id_valid_q;
        fetch_cnt_d     = fetch_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;

        if (redirect && Jump) begin
            pc_d = {JumpTarget[31:2], 2'b00};
        end else if (redirect) begin
            pc_d = {BranchTarget[31:2], 2'b00};
        end else if (PCWrite) begin
            pc_d = pc_plus4;
        end

        if (redirect) begin
            if_id_instr_d   = '0;
            if_id_pcplus4_d = '0;
            if_id_valid_d   = 1'b0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (IF_ID_Write) begin
            if_id_instr_d   = IM_Data;
            if_id_pcplus4_d = pc_plus4;
            if_id_valid_d   = 1'b1;
            if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_ONE;
        end

        if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q            <= RESET_PC;
            if_id_instr_q   <= '0;
            if_id_pcplus4_q <= '0;
            if_id_valid_q   <= 1'b0;
            fetch_cnt_q     <= '0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            pc_q            <= pc_d;
            if_id_instr_q   <= if_id_instr_d;
            if_id_pcplus4_q <= if_id_pcplus4_d;
            if_id_valid_q   <= if_id_valid_d;
            fetch_cnt_q     <= fetch_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign IM_Addr       = pc_q;
    assign PC            = pc_q;
    assign IF_ID_Instr   = if_id_instr_q;
    assign IF_ID_PCPlus4 = if_id_pcplus4_q;
    assign IF_ID_Rs      = if_id_instr_q[25:21];
    assign IF_ID_Rt      = if_id_instr_q[20:16];
    assign IF_ID_Valid   = if_id_valid_q;
    assign FetchCount    = fetch_cnt_q;
    assign StallCount    = stall_cnt_q;
    assign FlushCount    = flush_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model.
module tb_instruction_fetch_stage;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                PCWrite, IF_ID_Write, BranchTaken, Jump;
    logic [31:0]         BranchTarget, JumpTarget, IM_Data;
    logic [31:0]         IM_Addr, PC, IF_ID_Instr, IF_ID_PCPlus4;
    logic [4:0]          IF_ID_Rs, IF_ID_Rt;
    logic                IF_ID_Valid;
    logic [TB_CNT_W-1:0] FetchCount, StallCount, FlushCount;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    int          m_fetch, m_stall, m_flush;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(TB_CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump),
        .JumpTarget(JumpTarget), .IM_Data(IM_Data), .IM_Addr(IM_Addr), .PC(PC),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Valid(IF_ID_Valid),
        .FetchCount(FetchCount), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    // Address-tagged memory; address 0x40 holds the all-zero word (sll $0,$0,0).
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h40) return 32'h0;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign IM_Data = imem(IM_Addr);

    function automatic int sat_inc(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    PC, m_pc);
        chk({tag, ".addr"},  IM_Addr, m_pc);
        chk({tag, ".instr"}, IF_ID_Instr, m_instr);
        chk({tag, ".pp4"},   IF_ID_PCPlus4, m_pp4);
        chk({tag, ".valid"}, 32'(IF_ID_Valid), 32'(m_valid));
        chk({tag, ".rs"},    32'(IF_ID_Rs), 32'(m_instr[25:21]));
        chk({tag, ".rt"},    32'(IF_ID_Rt), 32'(m_instr[20:16]));
        chk({tag, ".fetch"}, 32'(FetchCount), 32'(m_fetch));
        chk({tag, ".stall"}, 32'(StallCount), 32'(m_stall));
        chk({tag, ".flush"}, 32'(FlushCount), 32'(m_flush));
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, then check.
    task automatic cycle(input string tag, input logic pcw, input logic ifw,
                         input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        logic honored;
        PCWrite = pcw; IF_ID_Write = ifw; BranchTaken = br; BranchTarget = bt;
        Jump = j; JumpTarget = jt;
        honored = pcw && (j || br);
        if (honored) begin
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            m_flush = sat_inc(m_flush);
        end else if (ifw) begin
            m_instr = imem(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_fetch = sat_inc(m_fetch);
        end
        if (!pcw) m_stall = sat_inc(m_stall);
        if (honored) m_pc = (j ? jt : bt) & ~32'd3;
        else if (pcw) m_pc = m_pc + 32'd4;
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic advance(input string tag);
        cycle(tag, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        PCWrite = 1'b1; IF_ID_Write = 1'b1; BranchTaken = 1'b1; Jump = 1'b1;
        BranchTarget = $urandom; JumpTarget = $urandom;
        model_reset();
        @(posedge Clk);
        #1;
        check_all("in_reset");
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        PCWrite = 1'b0; IF_ID_Write = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
        #2;
        do_reset();

        // straight-line fetch
        for (int i = 0; i < 3; i++) advance("seq");
        chk("seq_pc12", PC, 32'd12);
        chk("seq_fetch3", 32'(FetchCount), 32'd3);
        chk("seq_pp4_12", IF_ID_PCPlus4, 32'd12);

        // stall at PC=8
        do_reset();
        advance("seq2");
        advance("seq2");
        cycle("stall", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle("stall", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        chk("stall_pc8", PC, 32'd8);
        chk("stall_cnt2", 32'(StallCount), 32'd2);
        advance("resume");
        chk("resume_pc12", PC, 32'd12);

        // independent enables
        cycle("pc_only", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle("ifid_only", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // branch at PC=16 with misaligned target
        chk("pre_branch_pc16", PC, 32'd16);
        cycle("branch", 1'b1, 1'b1, 1'b1, 32'h41, 1'b0, 32'h0);
        chk("branch_pc40", PC, 32'h40);
        chk("branch_flush1", 32'(FlushCount), 32'd1);
        advance("zero_word");
        chk("zero_word_valid", 32'(IF_ID_Valid), 32'd1);

        // jump beats branch; stalled redirect is ignored
        cycle("jump_prio", 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
        chk("jump_pc100", PC, 32'h100);
        cycle("stalled_redir", 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h500);
        chk("stalled_redir_pc", PC, 32'h100);
        chk("stalled_redir_flush", 32'(FlushCount), 32'd2);

        // PC wraps modulo 2^32
        cycle("jump_top", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        chk("top_pc", PC, 32'hFFFF_FFFC);
        advance("wrap");
        chk("wrap_pc0", PC, 32'h0);
        chk("wrap_pp4_0", IF_ID_PCPlus4, 32'h0);
        chk("wrap_valid", 32'(IF_ID_Valid), 32'd1);

        // asynchronous reset mid-stall at PC=0x20
        cycle("jump20", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
        cycle("stall20", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        PCWrite = 1'b0;
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge Clk);
        #1;
        check_all("async_rst_hold");
        Reset = 1'b0;
        advance("post_rst");
        chk("post_rst_instr", IF_ID_Instr, imem(32'h0));

        // random traffic, includes counter saturation
        for (int i = 0; i < 300; i++) begin
            logic pcw, ifw, br, j;
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 7) == 0);
            j   = ($urandom_range(0, 9) == 0);
            cycle("rand", pcw, ifw, br, $urandom, j, $urandom);
        end
        chk("sat_fetch", 32'(FetchCount), 32'(CNT_MAX));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 32, width of each performance counter.
REQ-003 Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 PCWrite  input  1  1 = PC may update; 0 = hold PC (hazard stall).
REQ-006 IF_ID_Write  input  1  1 = IF/ID register may load; 0 = hold IF/ID.
REQ-007 BranchTaken  input  1  taken branch resolved in ID this cycle.
REQ-008 BranchTarget  input  32  branch destination address.
REQ-009 Jump  input  1  jump resolved in ID this cycle.
REQ-010 JumpTarget  input  32  jump destination address.
REQ-011 IM_Data  input  32  instruction word read combinationally at IM_Addr.
REQ-012 IM_Addr  output  32  instruction memory address, equal to PC.
REQ-013 PC  output  32  current fetch PC.
REQ-014 IF_ID_Instr  output  32  registered instruction for ID.
REQ-015 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-016 IF_ID_Rs  output  5  IF_ID_Instr[25:21].
REQ-017 IF_ID_Rt  output  5  IF_ID_Instr[20:16].
REQ-018 IF_ID_Valid  output  1  1 = IF/ID holds a real fetched instruction.
REQ-019 FetchCount, StallCount, FlushCount  output  CNT_W each  performance counters.

Function
REQ-020 IM_Addr SHALL equal PC combinationally; PC+4 SHALL wrap modulo 2^32.
REQ-021 Redirect SHALL be honored only when PCWrite=1 and (Jump=1 or BranchTaken=1); with PCWrite=0, Jump/BranchTaken are ignored that cycle.
REQ-022 Next PC priority: honored Jump -> JumpTarget; else honored BranchTaken -> BranchTarget; else PCWrite=1 -> PC+4; else hold.
REQ-023 Low two bits of any loaded target SHALL be forced to 2'b00.
REQ-024 On honored redirect, IF/ID SHALL load bubble: Instr=0, PCPlus4=0, Valid=0, overriding IF_ID_Write.
REQ-025 Otherwise IF_ID_Write=1 loads Instr=IM_Data, PCPlus4=PC+4, Valid=1; IF_ID_Write=0 holds all IF/ID fields.
REQ-026 PCWrite and IF_ID_Write SHALL act independently when not redirecting; no inference across them.
REQ-027 IF_ID_Rs/IF_ID_Rt SHALL be combinational slices of registered IF_ID_Instr.
REQ-028 FetchCount +1 per cycle IF/ID loads with Valid=1; StallCount +1 per cycle PCWrite=0; FlushCount +1 per honored redirect.
REQ-029 Counters SHALL saturate at all-ones, no wrap.
REQ-030 Instruction word 0 (sll $0,$0,0) is treated as ordinary data; Valid alone marks bubbles.

Reset
REQ-031 Reset=1 SHALL asynchronously set PC=RESET_PC, IF_ID_Instr=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, all counters=0.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL discard that cycle's update; first fetch after release is from RESET_PC.
REQ-033 While Reset=1, all inputs SHALL be ignored.

Verification
REQ-034 Reset release, PCWrite=IF_ID_Write=1, IM_Data=addr-tagged, 3 cycles -> PC 0,4,8,12; IF_ID_PCPlus4 4,8,12; Valid=1; FetchCount=3.
REQ-035 At PC=8, PCWrite=IF_ID_Write=0 for 2 cycles -> PC stays 8, IF/ID unchanged, StallCount=2; resumes at 12.
REQ-036 At PC=16, BranchTaken=1, BranchTarget=0x41 -> next PC=0x40, IF_ID_Valid=0, IF_ID_Instr=0, FlushCount=1.
REQ-037 Jump=1 (JumpTarget=0x100) and BranchTaken=1 (0x200) same cycle -> PC=0x100; with PCWrite=0 same cycle -> PC holds, FlushCount unchanged.
REQ-038 PC=0xFFFF_FFFC, advance -> PC=0, IF_ID_PCPlus4=0, Valid=1.
REQ-039 Reset pulsed between clock edges during stall at PC=0x20 -> PC=RESET_PC immediately, Valid=0, counters 0.
